// File: rtl/comm_slave.sv
`default_nettype none
// ============================================================================
// Module   : comm_slave
// Purpose  : Copter-side end of the wireless command link. Receives 8N1 UART
//            bytes, assembles 3-byte frames (cmd, data_hi, data_lo) for the
//            flight command handler, and returns a single response byte.
// Revision : 1.0 - initial release
// ============================================================================
module comm_slave #(
  parameter int BAUD_DIV  = 2604,
  parameter int FRAME_TMO = 262144
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(FRAME_TMO);
  localparam logic [BW-1:0] c_baud_last = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] c_baud_half = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] c_tmo_last  = TW'(FRAME_TMO - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} asm_state_t;
  typedef enum logic       {TX_IDLE, TX_XMIT} tx_state_t;

  rx_state_t  r_rx_state, w_rx_nxt;
  asm_state_t r_asm_state, w_asm_nxt;
  tx_state_t  r_tx_state, w_tx_nxt;

  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic [BW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic [7:0]    r_cmd_shadow, r_hi_shadow;
  logic [TW-1:0] r_tmo_cnt;
  logic [BW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [9:0]    r_tx_sh;

  logic w_rx_tick, w_rx_start, w_byte_done, w_frm_err;
  logic w_tmo_run, w_tmo, w_tx_tick, w_tx_load, w_tx_done;

  assign w_rx_tick = (r_rx_cnt == '0);
  assign w_tx_tick = (r_tx_cnt == '0);
  assign w_tmo_run = (r_asm_state != WAIT_CMD) && (r_rx_state == RX_IDLE);
  assign w_tmo     = w_tmo_run && (r_tmo_cnt == c_tmo_last);
  assign TX        = r_tx_sh[0];
  assign tx_busy   = (r_tx_state == TX_XMIT);

  // Two-flop synchronizer plus history flop; preset high so reset is not a start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= RX;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // State registers for all three FSMs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= RX_IDLE;
      r_asm_state <= WAIT_CMD;
      r_tx_state  <= TX_IDLE;
    end else begin
      r_rx_state  <= w_rx_nxt;
      r_asm_state <= w_asm_nxt;
      r_tx_state  <= w_tx_nxt;
    end
  end

  // RX next state; byte_done/framing error are decided at the stop-bit sample
  always_comb begin
    w_rx_nxt    = r_rx_state;
    w_rx_start  = 1'b0;
    w_byte_done = 1'b0;
    w_frm_err   = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !r_rx_s2) begin
                  w_rx_nxt   = RX_START;
                  w_rx_start = 1'b1;
                end
      RX_START: if (w_rx_tick) w_rx_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP:  if (w_rx_tick) begin
                  w_rx_nxt    = RX_IDLE;
                  w_byte_done = r_rx_s2;
                  w_frm_err   = !r_rx_s2;
                end
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  // RX baud counter, bit counter and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
    end else if (w_rx_start) begin
      r_rx_cnt <= c_baud_half;
      r_rx_bit <= '0;
    end else if (r_rx_state != RX_IDLE) begin
      if (w_rx_tick) begin
        r_rx_cnt <= c_baud_last;
        if (r_rx_state == RX_DATA) begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 3'd1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt - 1'b1;
      end
    end
  end

  // Frame assembler next state; errors and timeouts restart the frame
  always_comb begin
    w_asm_nxt = r_asm_state;
    if (w_frm_err || w_tmo) begin
      w_asm_nxt = WAIT_CMD;
    end else if (w_byte_done) begin
      case (r_asm_state)
        WAIT_CMD: w_asm_nxt = WAIT_HI;
        WAIT_HI:  w_asm_nxt = WAIT_LO;
        default:  w_asm_nxt = WAIT_CMD;
      endcase
    end
  end

  // Shadows hold a partial frame; cmd/data only move when the frame completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_shadow <= '0;
      r_hi_shadow  <= '0;
      cmd          <= '0;
      data         <= '0;
      cmd_rdy      <= 1'b0;
    end else begin
      if (w_byte_done && r_asm_state == WAIT_CMD) r_cmd_shadow <= r_rx_sh;
      if (w_byte_done && r_asm_state == WAIT_HI)  r_hi_shadow  <= r_rx_sh;
      if (w_byte_done && r_asm_state == WAIT_LO) begin
        cmd     <= r_cmd_shadow;
        data    <= {r_hi_shadow, r_rx_sh};
        cmd_rdy <= 1'b1;
      end else if (w_byte_done && r_asm_state == WAIT_CMD) begin
        cmd_rdy <= 1'b0;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  // Inter-byte idle counter; cleared on every start detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_tmo_cnt <= '0;
    else if (!w_tmo_run || w_rx_start || w_tmo) r_tmo_cnt <= '0;
    else                             r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // TX next state; requests while transmitting are dropped
  always_comb begin
    w_tx_nxt  = r_tx_state;
    w_tx_load = 1'b0;
    w_tx_done = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (send_resp) begin
                 w_tx_nxt  = TX_XMIT;
                 w_tx_load = 1'b1;
               end
      TX_XMIT: if (w_tx_tick && r_tx_bit == 4'd9) begin
                 w_tx_nxt  = TX_IDLE;
                 w_tx_done = 1'b1;
               end
      default: w_tx_nxt = TX_IDLE;
    endcase
  end

  // TX shifter: bit 0 drives the line, ones fill in so the line idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sh   <= '1;
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
      resp_sent <= 1'b0;
    end else begin
      resp_sent <= w_tx_done;
      if (w_tx_load) begin
        r_tx_sh  <= {1'b1, resp, 1'b0};
        r_tx_cnt <= c_baud_last;
        r_tx_bit <= '0;
      end else if (r_tx_state == TX_XMIT) begin
        if (w_tx_tick) begin
          r_tx_cnt <= c_baud_last;
          r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
          r_tx_bit <= r_tx_bit + 4'd1;
        end else begin
          r_tx_cnt <= r_tx_cnt - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
